// File: rtl/controle_jogo_matriz.sv
// controle_jogo_matriz
// Game-sequencing control unit for the 8x8 LED-matrix puzzle.
// Conditions the raw start and puzzle buttons into one-cycle pulses. Forwards
// puzzle-button pulses to the matrix controller only while a level is being
// played. Counts moves against a per-level limit. Steps through the levels on
// the matrix completion flag, and ends the game in a win or a loss.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   iniciar         raw start button (asynchronous)
//   botoes_brutos   raw puzzle buttons (asynchronous)
//   nivel_concluido level-complete flag from the matrix controller
//   botoes          one-cycle toggle pulses to the matrix controller
//   nivel           current level, 0..4
//   limpa_matriz    one-cycle matrix clear request
//   jogadas         moves made in the current level
//   jogando         high while the level is being played
//   vitoria         high after the last level is completed
//   derrota         high after the move limit ran out
module controle_jogo_matriz #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int ESPERA_CICLOS   = 25000000,
    parameter int MAX_JOGADAS     = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
    input  logic [7:0] botoes_brutos,
    input  logic       nivel_concluido,
    output logic [7:0] botoes,
    output logic [2:0] nivel,
    output logic       limpa_matriz,
    output logic [7:0] jogadas,
    output logic       jogando,
    output logic       vitoria,
    output logic       derrota
);
    localparam int PW = $clog2(DEBOUNCE_CICLOS);
    localparam int EW = (ESPERA_CICLOS > 1) ? $clog2(ESPERA_CICLOS) : 1;
    localparam logic [PW-1:0] PRESC_FIM  = PW'(DEBOUNCE_CICLOS - 1);
    localparam logic [EW-1:0] ESPERA_FIM = EW'(ESPERA_CICLOS - 1);
    localparam logic [7:0]    MAX_J      = 8'(MAX_JOGADAS);
    localparam logic [7:0]    ULTIMA     = 8'(MAX_JOGADAS - 1);

    typedef enum logic [2:0] {
        OCIOSO, LIMPA, PREPARA, JOGANDO, VERIFICA, CONCLUIDO, VITORIA, DERROTA
    } estado_t;

    // ---------------- input conditioning ----------------
    // Bit 8 carries the start button and bits 7:0 carry the puzzle buttons.
    logic [8:0]    sinc1, sinc2, amostra, estavel, estavel_novo, concorda, pulso;
    logic [PW-1:0] presc;
    logic          tick;

    assign tick     = (presc == PRESC_FIM);
    // A bit follows the sample only when it agrees with the previous sample.
    assign concorda     = ~(sinc2 ^ amostra);
    assign estavel_novo = (concorda & sinc2) | (~concorda & estavel);

    always_ff @(posedge clk) begin
        if (rst) begin
            sinc1   <= '0;
            sinc2   <= '0;
            presc   <= '0;
            amostra <= '0;
            estavel <= '0;
            pulso   <= '0;
        end else begin
            sinc1 <= {iniciar, botoes_brutos};
            sinc2 <= sinc1;
            presc <= tick ? '0 : presc + PW'(1);
            pulso <= '0;
            if (tick) begin
                amostra <= sinc2;
                estavel <= estavel_novo;
                pulso   <= estavel_novo & ~estavel;  // rising edges only
            end
        end
    end

    // ---------------- game FSM ----------------
    estado_t       estado, prox;
    logic          fase;    // second cycle of PREPARA / VERIFICA
    logic [EW-1:0] espera;  // cycles spent in CONCLUIDO

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
            fase   <= 1'b0;
            espera <= '0;
        end else begin
            estado <= prox;
            fase   <= (prox == estado) ? ~fase : 1'b0;
            espera <= (estado == CONCLUIDO && prox == CONCLUIDO) ? espera + EW'(1) : '0;
        end
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO, VITORIA, DERROTA: if (pulso[8]) prox = LIMPA;
            LIMPA:    prox = PREPARA;
            // The matrix flag is still settling here, so it is not looked at.
            PREPARA:  if (fase) prox = JOGANDO;
            // Completion is tested first, so it wins over the limit-reaching move.
            JOGANDO: begin
                if (nivel_concluido)                     prox = CONCLUIDO;
                else if ((|botoes) && jogadas == ULTIMA) prox = VERIFICA;
            end
            VERIFICA: begin
                if (nivel_concluido) prox = CONCLUIDO;
                else if (fase)       prox = DERROTA;
            end
            CONCLUIDO: if (espera == ESPERA_FIM) prox = (nivel == 3'd4) ? VITORIA : LIMPA;
            default:  prox = OCIOSO;
        endcase
    end

    // ---------------- registered outputs ----------------
    logic [7:0] botoes_d, jogadas_d;
    logic [2:0] nivel_d;
    logic       limpa_d, jogando_d, vitoria_d, derrota_d;

    always_comb begin
        // A pulse is forwarded only if the FSM stays in play. Anything that
        // arrives while leaving JOGANDO is dropped.
        botoes_d = '0;
        if (estado == JOGANDO && prox == JOGANDO) botoes_d = pulso[7:0];
        nivel_d = nivel;
        if (prox == LIMPA) nivel_d = (estado == CONCLUIDO) ? nivel + 3'd1 : 3'd0;
        jogadas_d = jogadas;
        if (prox == LIMPA)                       jogadas_d = '0;
        else if ((|botoes) && jogadas != MAX_J)  jogadas_d = jogadas + 8'd1;
        limpa_d   = (prox == LIMPA);
        jogando_d = (prox == JOGANDO);
        vitoria_d = (prox == VITORIA);
        derrota_d = (prox == DERROTA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            botoes       <= '0;
            nivel        <= '0;
            limpa_matriz <= 1'b0;
            jogadas      <= '0;
            jogando      <= 1'b0;
            vitoria      <= 1'b0;
            derrota      <= 1'b0;
        end else begin
            botoes       <= botoes_d;
            nivel        <= nivel_d;
            limpa_matriz <= limpa_d;
            jogadas      <= jogadas_d;
            jogando      <= jogando_d;
            vitoria      <= vitoria_d;
            derrota      <= derrota_d;
        end
    end
endmodule

// File: tb/tb_controle_jogo_matriz.sv
// Directed bench for controle_jogo_matriz with short debounce, wait and
// move-limit parameters.
module tb_controle_jogo_matriz;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iniciar = 1'b0;
    logic [7:0] botoes_brutos = '0;
    logic       nivel_concluido = 1'b0;
    logic [7:0] botoes;
    logic [2:0] nivel;
    logic       limpa_matriz;
    logic [7:0] jogadas;
    logic       jogando, vitoria, derrota;

    controle_jogo_matriz #(
        .DEBOUNCE_CICLOS(4),
        .ESPERA_CICLOS  (8),
        .MAX_JOGADAS    (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .iniciar        (iniciar),
        .botoes_brutos  (botoes_brutos),
        .nivel_concluido(nivel_concluido),
        .botoes         (botoes),
        .nivel          (nivel),
        .limpa_matriz   (limpa_matriz),
        .jogadas        (jogadas),
        .jogando        (jogando),
        .vitoria        (vitoria),
        .derrota        (derrota)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event recorder, sampled on the falling edge.
    int         cyc = 0;
    int         n_pulsos = 0, n_ciclos_btn = 0, n_limpa = 0;
    int         c_btn = 0, c_limpa = 0, c_jog_sobe = 0, c_jog_desce = 0, c_der_sobe = 0;
    logic [7:0] ult_btn = '0, btn_ant = '0;
    logic [2:0] nivel_limpa = '0;
    logic       jog_ant = 1'b0, der_ant = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (botoes != 8'h00) begin
            n_ciclos_btn++;
            ult_btn = botoes;
            c_btn   = cyc;
            if (btn_ant == 8'h00) n_pulsos++;
        end
        if (limpa_matriz === 1'b1) begin
            n_limpa++;
            c_limpa     = cyc;
            nivel_limpa = nivel;
        end
        if (jogando === 1'b1 && !jog_ant) c_jog_sobe  = cyc;
        if (jogando === 1'b0 &&  jog_ant) c_jog_desce = cyc;
        if (derrota === 1'b1 && !der_ant) c_der_sobe  = cyc;
        btn_ant = botoes;
        jog_ant = (jogando === 1'b1);
        der_ant = (derrota === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iniciar = 1'b0;
        botoes_brutos = '0;
        nivel_concluido = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press_start();
        iniciar = 1'b1;
        repeat (24) tick();
        iniciar = 1'b0;
        repeat (24) tick();
    endtask

    task automatic press_btn(input int idx);
        botoes_brutos[idx] = 1'b1;
        repeat (24) tick();
        botoes_brutos[idx] = 1'b0;
        repeat (24) tick();
    endtask

    task automatic wait_jogando(input string nome);
        for (int i = 0; i < 200; i++) begin
            if (jogando) break;
            tick();
        end
        if (!jogando) begin
            total++; bad++;
            $display("FAIL %s timeout waiting jogando", nome);
        end
    endtask

    // Play one level by raising the completion flag for one JOGANDO cycle.
    task automatic complete_level(input string nome);
        wait_jogando(nome);
        nivel_concluido = 1'b1;
        tick();
        nivel_concluido = 1'b0;
    endtask

    task automatic test_reset();
        int p0;
        do_reset();
        total++;
        if ({botoes, nivel, limpa_matriz, jogadas, jogando, vitoria, derrota} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {botoes, nivel, limpa_matriz, jogadas, jogando, vitoria, derrota});
        end
        p0 = n_pulsos;
        press_btn(5);
        total++;
        if (n_pulsos - p0 != 0) begin
            bad++; $display("FAIL idle_button pulses got=%0d exp=0", n_pulsos - p0);
        end
        total++;
        if (jogadas !== 8'd0 || jogando !== 1'b0) begin
            bad++; $display("FAIL idle_state jogadas=%0d jogando=%b exp 0/0", jogadas, jogando);
        end
    endtask

    task automatic test_debounce();
        int p0, w0;
        do_reset();
        press_start();
        wait_jogando("deb_start");
        p0 = n_pulsos;
        w0 = n_ciclos_btn;
        for (int i = 0; i < 6; i++) begin
            botoes_brutos[3] = (i % 2 == 0);
            tick();
        end
        botoes_brutos[3] = 1'b1;
        repeat (30) tick();
        total++;
        if (n_pulsos - p0 != 1) begin
            bad++; $display("FAIL deb_pulses got=%0d exp=1", n_pulsos - p0);
        end
        total++;
        if (n_ciclos_btn - w0 != 1) begin
            bad++; $display("FAIL deb_width got=%0d exp=1", n_ciclos_btn - w0);
        end
        total++;
        if (ult_btn !== 8'h08) begin
            bad++; $display("FAIL deb_value got=%h exp=08", ult_btn);
        end
        total++;
        if (jogadas !== 8'd1) begin
            bad++; $display("FAIL deb_jogadas got=%0d exp=1", jogadas);
        end
        botoes_brutos[3] = 1'b0;
        repeat (30) tick();
        total++;
        if (n_pulsos - p0 != 1) begin
            bad++; $display("FAIL deb_release pulses got=%0d exp=1", n_pulsos - p0);
        end
    endtask

    task automatic test_move_limit();
        int p0;
        do_reset();
        press_start();
        wait_jogando("lim_start");
        p0 = n_pulsos;
        for (int k = 0; k < 3; k++) press_btn(0);
        total++;
        if (n_pulsos - p0 != 3) begin
            bad++; $display("FAIL lim_pulses got=%0d exp=3", n_pulsos - p0);
        end
        total++;
        if (jogadas !== 8'd3) begin
            bad++; $display("FAIL lim_jogadas got=%0d exp=3", jogadas);
        end
        total++;
        if (derrota !== 1'b1 || jogando !== 1'b0) begin
            bad++; $display("FAIL lim_derrota got=%b/%b exp derrota=1 jogando=0", derrota, jogando);
        end
        total++;
        if (c_der_sobe - c_btn != 3) begin
            bad++; $display("FAIL lim_latency got=%0d exp=3", c_der_sobe - c_btn);
        end
        press_btn(0);
        total++;
        if (n_pulsos - p0 != 3 || jogadas !== 8'd3) begin
            bad++; $display("FAIL lim_fourth pulses=%0d jogadas=%0d exp 3/3", n_pulsos - p0, jogadas);
        end
    endtask

    task automatic test_completion_beats_limit();
        int   d0, l0;
        logic got;
        do_reset();
        press_start();
        wait_jogando("cbl_start");
        press_btn(1);
        press_btn(1);
        d0 = c_der_sobe;
        l0 = n_limpa;
        got = 1'b0;
        botoes_brutos[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (botoes != 8'h00) begin got = 1'b1; break; end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL cbl_third_pulse timeout got=0 exp=1");
        end
        @(posedge clk);
        @(posedge clk);
        #1 nivel_concluido = 1'b1;
        @(posedge clk);
        #1 nivel_concluido = 1'b0;
        botoes_brutos[1] = 1'b0;
        repeat (30) tick();
        total++;
        if (derrota !== 1'b0 || c_der_sobe != d0) begin
            bad++; $display("FAIL cbl_derrota got=%b exp=0", derrota);
        end
        total++;
        if (n_limpa - l0 != 1 || nivel !== 3'd1) begin
            bad++; $display("FAIL cbl_advance limpa=%0d nivel=%0d exp 1/1", n_limpa - l0, nivel);
        end
        total++;
        if (jogando !== 1'b1 || jogadas !== 8'd0) begin
            bad++; $display("FAIL cbl_next_level jogando=%b jogadas=%0d exp 1/0", jogando, jogadas);
        end
    endtask

    task automatic test_level_advance();
        int   l0, w0;
        logic got;
        do_reset();
        press_start();
        complete_level("adv_l0");
        complete_level("adv_l1");
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (jogando === 1'b1 && nivel === 3'd2) begin got = 1'b1; break; end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL adv_reach_l2 timeout nivel=%0d exp=2", nivel);
        end
        l0 = n_limpa;
        w0 = n_ciclos_btn;
        nivel_concluido = 1'b1;  // held through CONCLUIDO, LIMPA and PREPARA
        for (int i = 0; i < 60; i++) begin
            tick();
            if (n_limpa != l0 && jogando) break;
        end
        nivel_concluido = 1'b0;
        repeat (2) tick();
        total++;
        if (c_limpa - c_jog_desce != 8) begin
            bad++; $display("FAIL adv_wait got=%0d exp=8", c_limpa - c_jog_desce);
        end
        total++;
        if (c_jog_sobe - c_limpa != 3) begin
            bad++; $display("FAIL adv_prepara got=%0d exp=3", c_jog_sobe - c_limpa);
        end
        total++;
        if (nivel_limpa !== 3'd3 || nivel !== 3'd3) begin
            bad++; $display("FAIL adv_nivel got=%0d/%0d exp=3", nivel_limpa, nivel);
        end
        total++;
        if (n_limpa - l0 != 1 || jogando !== 1'b1) begin
            bad++; $display("FAIL adv_play limpa=%0d jogando=%b exp 1/1", n_limpa - l0, jogando);
        end
        total++;
        if (n_ciclos_btn != w0) begin
            bad++; $display("FAIL adv_blocked got=%0d exp=0", n_ciclos_btn - w0);
        end
    endtask

    task automatic test_full_game();
        int l0;
        do_reset();
        press_start();
        for (int lv = 0; lv < 5; lv++) complete_level("full_level");
        for (int i = 0; i < 50; i++) begin
            if (vitoria) break;
            tick();
        end
        total++;
        if (vitoria !== 1'b1 || nivel !== 3'd4 || jogando !== 1'b0) begin
            bad++; $display("FAIL full_win vitoria=%b nivel=%0d jogando=%b exp 1/4/0", vitoria, nivel, jogando);
        end
        l0 = n_limpa;
        press_start();
        total++;
        if (n_limpa - l0 != 1 || nivel_limpa !== 3'd0) begin
            bad++; $display("FAIL full_restart limpa=%0d nivel=%0d exp 1/0", n_limpa - l0, nivel_limpa);
        end
        total++;
        if (vitoria !== 1'b0 || nivel !== 3'd0 || jogando !== 1'b1) begin
            bad++; $display("FAIL full_after_restart vitoria=%b nivel=%0d jogando=%b exp 0/0/1", vitoria, nivel, jogando);
        end
        // Reset while CONCLUIDO is holding the pattern.
        complete_level("full_mid");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({botoes, nivel, limpa_matriz, jogadas, jogando, vitoria, derrota} !== 23'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h exp=0",
                     {botoes, nivel, limpa_matriz, jogadas, jogando, vitoria, derrota});
        end
        l0 = n_limpa;
        repeat (20) tick();
        total++;
        if (n_limpa != l0 || jogando !== 1'b0 || nivel !== 3'd0) begin
            bad++; $display("FAIL midreset_idle limpa=%0d jogando=%b nivel=%0d exp 0/0/0", n_limpa - l0, jogando, nivel);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_move_limit();
        test_completion_beats_limit();
        test_level_advance();
        test_full_game();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controle_jogo_matriz.md
# controle_jogo_matriz

Game-sequencing control unit for the 8×8 LED-matrix puzzle. It sits between the physical buttons and the matrix controller:
- conditions raw button inputs into one-cycle toggle pulses;
- drives the current level and matrix clear;
- counts moves against a per-level limit;
- advances levels on the matrix's completion flag, ending in a win or loss state.

## Interface
- DEBOUNCE_CICLOS, 50000, cycles between debounce samples (≥2)
- ESPERA_CICLOS, 25000000, cycles the completed pattern stays displayed before the next level (≥1)
- MAX_JOGADAS, 30, move limit per level (1..255)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- iniciar  in  1  raw start button, asynchronous
- botoes_brutos  in  8  raw puzzle buttons, asynchronous
- nivel_concluido  in  1  completion flag from the matrix controller (registered there)
- botoes  out  8  one-cycle toggle pulses to the matrix controller
- nivel  out  3  current level, 0..4
- limpa_matriz  out  1  one-cycle matrix clear request
- jogadas  out  8  moves made in the current level
- jogando  out  1  high while in JOGANDO
- vitoria  out  1  high in VITORIA
- derrota  out  1  high in DERROTA

## Operation
- **Input sync:** `iniciar` and `botoes_brutos` each pass through a 2-flop synchronizer.
- **Debounce:**
  - One shared prescaler produces a tick every DEBOUNCE_CICLOS cycles.
  - On each tick, each of the 9 inputs is sampled.
  - A debounced bit takes the sampled value only when two consecutive samples agree.
  - A rising edge of a debounced bit produces an internal 1-cycle pulse. Falling edges produce nothing.
- **Button forwarding:**
  - Button pulses reach `botoes` only in JOGANDO. In any other state they are discarded, not queued.
  - Simultaneous pulses are forwarded together and count as one move.
- **jogadas:** increments by 1 on every cycle in which `botoes` ≠ 0. It is cleared in LIMPA and never exceeds MAX_JOGADAS.
- **States:**
  - OCIOSO: outputs idle. `iniciar` pulse → `nivel`=0, go to LIMPA.
  - LIMPA (1 cycle): `limpa_matriz`=1, `jogadas`=0 → PREPARA.
  - PREPARA (2 cycles): `nivel_concluido` is ignored while the matrix's registered flag settles → JOGANDO.
  - JOGANDO:
    - `nivel_concluido`=1 → CONCLUIDO.
    - A forwarded move that makes `jogadas`=MAX_JOGADAS → VERIFICA.
  - VERIFICA (2 cycles, buttons blocked): lets the last move propagate through the matrix.
    - `nivel_concluido` seen in either cycle → CONCLUIDO.
    - Otherwise → DERROTA.
  - CONCLUIDO: waits ESPERA_CICLOS cycles with buttons blocked and the pattern still displayed. Then:
    - `nivel`=4 → VITORIA.
    - Otherwise `nivel`+1 → LIMPA.
  - VITORIA / DERROTA: hold. An `iniciar` pulse → `nivel`=0 → LIMPA.
- **Start button outside OCIOSO/VITORIA/DERROTA:** an `iniciar` pulse is ignored.
- **Priority:** completion beats move limit. If `nivel_concluido` and the limit-reaching move coincide, go to CONCLUIDO.
- **Reset mid-operation:** returns to OCIOSO from any state. Counters, prescaler and debounce state clear; all debounced bits go to 0.
- **nivel:** never exceeds 4 and never wraps.

## Timing
- **Reset values:** `botoes`=0, `nivel`=0, `limpa_matriz`=0, `jogadas`=0, `jogando`=0, `vitoria`=0, `derrota`=0. State is OCIOSO.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.
- **Button latency:**
  - Raw edge → `botoes` pulse takes 2 sync cycles + 2 to 3 ticks + 1 cycle.
  - The pulse is exactly 1 cycle wide, one per press.
  - Button bounce shorter than one tick period produces no extra pulse.
- **Clear and play window:**
  - `limpa_matriz` is high for exactly 1 cycle.
  - `jogando` rises 3 cycles after `limpa_matriz` (after LIMPA plus the 2-cycle PREPARA).
- **Completion and level advance:**
  - Completion is taken on the first cycle JOGANDO sees `nivel_concluido`=1.
  - `nivel` increments on the cycle CONCLUIDO exits to LIMPA, so it is already updated when `limpa_matriz` pulses.

## Test plan
- **Reset:** reset held for 3 cycles, released → all outputs 0, state OCIOSO. A button press in OCIOSO → `botoes` stays 0.
- **Debounce** (DEBOUNCE_CICLOS=4):
  - `botoes_brutos[3]` bounces 0/1 every cycle for 6 cycles, then holds 1 → exactly one 1-cycle pulse `botoes`=8'h08 and `jogadas`=1.
  - Release → no pulse.
- **Level advance** (ESPERA_CICLOS=8):
  - `iniciar`, then `nivel_concluido` forced to 1 during JOGANDO at level 2 → `botoes` blocked for 8 cycles.
  - Then `nivel`=3 and a `limpa_matriz` pulse; `jogando` high 3 cycles later.
  - The flag held high during PREPARA is ignored.
- **Move limit** (MAX_JOGADAS=3): 3 presses with `nivel_concluido`=0 → `jogadas`=3, `derrota`=1 exactly 3 cycles after the 3rd `botoes` pulse. A 4th press → no pulse.
- **Completion beats limit:** 3rd press with `nivel_concluido` asserted 2 cycles after its pulse → CONCLUIDO, `derrota` stays 0.
- **Full game and restart:**
  - Completing levels 0–4 → `vitoria`=1 with `nivel`=4.
  - An `iniciar` pulse → `nivel`=0, `limpa_matriz` pulse, `vitoria`=0.
  - `rst` asserted mid-CONCLUIDO → OCIOSO, all outputs 0.
